// File: rtl/xilinx_distram_fifo.sv
// Single-clock FIFO over a dual-port distributed LUT RAM (async read port)
// with a registered valid/ready output stage; COUNT covers RAM plus output reg.
module xilinx_distram_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] S_DATA,
  input  logic                  S_VALID,
  output logic                  S_READY,
  output logic [DATA_WIDTH-1:0] M_DATA,
  output logic                  M_VALID,
  input  logic                  M_READY,
  output logic [ADDR_WIDTH:0]   COUNT
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   ram_cnt, ram_cnt_next;
  logic [DATA_WIDTH-1:0] dpo;
  logic                  push, load;

  assign push = S_VALID && S_READY;
  assign load = (ram_cnt != '0) && (!M_VALID || M_READY);
  assign dpo  = ram[rd_ptr];
  assign COUNT = ram_cnt + (ADDR_WIDTH+1)'(M_VALID);

  always_comb begin
    ram_cnt_next = ram_cnt;
    case ({push, load})
      2'b10:   ram_cnt_next = ram_cnt + (ADDR_WIDTH+1)'(1);
      2'b01:   ram_cnt_next = ram_cnt - (ADDR_WIDTH+1)'(1);
      default: ram_cnt_next = ram_cnt;
    endcase
  end

  // RAM is never reset; empty implies rd_ptr == wr_ptr so stale words are unreachable.
  always_ff @(posedge CLK) begin
    if (push) ram[wr_ptr] <= S_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ram_cnt <= '0;
      S_READY <= 1'b0;
      M_VALID <= 1'b0;
      M_DATA  <= '0;
    end else begin
      ram_cnt <= ram_cnt_next;
      S_READY <= (ram_cnt_next < DEPTH_C);
      if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (load) begin
        rd_ptr  <= rd_ptr + ADDR_WIDTH'(1);
        M_DATA  <= dpo;
        M_VALID <= 1'b1;
      end else if (M_VALID && M_READY) begin
        M_VALID <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_xilinx_distram_fifo.sv
// Directed and random checks of xilinx_distram_fifo against a queue model.
module tb_xilinx_distram_fifo;
  localparam int AW = 5;
  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic [DW-1:0] S_DATA;
  logic          S_VALID;
  logic          S_READY;
  logic [DW-1:0] M_DATA;
  logic          M_VALID;
  logic          M_READY;
  logic [AW:0]   COUNT;

  xilinx_distram_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST),
    .S_DATA(S_DATA), .S_VALID(S_VALID), .S_READY(S_READY),
    .M_DATA(M_DATA), .M_VALID(M_VALID), .M_READY(M_READY),
    .COUNT(COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] last_out;
  logic          last_push, last_pop;
  int            n_push = 0, n_pop = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: model the handshakes seen before the edge, then sample 1ns after it.
  task automatic step();
    logic do_push, do_pop, stall, rst_now;
    logic [DW-1:0] held;
    rst_now = RST;
    do_push = !RST && S_VALID && S_READY;
    do_pop  = !RST && M_VALID && M_READY;
    stall   = !RST && M_VALID && !M_READY;
    held    = M_DATA;
    if (do_pop) begin
      if (q.size() == 0) chk("pop_underflow", 1, 0);
      else begin
        chk("pop_order", 32'(M_DATA), 32'(q[0]));
        void'(q.pop_front());
      end
      last_out = M_DATA;
      n_pop++;
    end
    if (do_push) begin
      q.push_back(S_DATA);
      n_push++;
    end
    last_push = do_push;
    last_pop  = do_pop;
    @(posedge CLK);
    #1;
    if (rst_now) q.delete();
    if (stall && !rst_now) begin
      chk("stall_valid", 32'(M_VALID), 1);
      chk("stall_data", 32'(M_DATA), 32'(held));
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_mvalid"}, 32'(M_VALID), 0);
    chk({tag, "_mdata"},  32'(M_DATA),  0);
    chk({tag, "_sready"}, 32'(S_READY), 0);
    chk({tag, "_count"},  32'(COUNT),   0);
  endtask

  initial begin
    int acc, pops0, cyc;
    logic [DW-1:0] nxt;
    int pv[4] = '{30, 90, 60, 90};
    int pr[4] = '{90, 30, 60, 90};

    RST = 1'b1; S_VALID = 1'b1; S_DATA = 8'h77; M_READY = 1'b0;
    last_out = '0; last_push = 1'b0; last_pop = 1'b0;

    // reset held 3 cycles with a write attempted throughout
    for (int i = 0; i < 3; i++) begin
      step();
      chk_reset_outs("reset");
    end
    RST = 1'b0; S_VALID = 1'b0;
    step();
    chk("ready_after_reset", 32'(S_READY), 1);
    chk("idle_count", 32'(COUNT), 0);
    step();
    chk("reset_push_dropped", 32'(COUNT), 0);
    chk("idle_mvalid", 32'(M_VALID), 0);

    // latency: push at edge N, visible after edge N+1
    S_DATA = 8'hA5; S_VALID = 1'b1;
    step();
    S_VALID = 1'b0;
    chk("lat_n_mvalid", 32'(M_VALID), 0);
    chk("lat_n_count", 32'(COUNT), 1);
    step();
    chk("lat_n1_mvalid", 32'(M_VALID), 1);
    chk("lat_n1_mdata", 32'(M_DATA), 8'hA5);
    chk("lat_n1_count", 32'(COUNT), 1);
    M_READY = 1'b1;
    step();
    M_READY = 1'b0;
    chk("lat_pop_mvalid", 32'(M_VALID), 0);
    chk("lat_pop_count", 32'(COUNT), 0);

    // fill with the output stalled: 32 in RAM + 1 in output register
    acc = 0;
    for (int d = 0; d <= 8'h40; d++) begin
      S_DATA = 8'(d); S_VALID = 1'b1;
      step();
      if (last_push) acc++;
    end
    S_VALID = 1'b0;
    chk("fill_accepted", acc, 33);
    chk("fill_sready", 32'(S_READY), 0);
    chk("fill_count", 32'(COUNT), 33);
    M_READY = 1'b1;
    for (int i = 0; i <= 8'h20; i++) begin
      chk("drain_mvalid", 32'(M_VALID), 1);
      chk("drain_data", 32'(M_DATA), i);
      step();
      if (i == 0) chk("ready_after_first_pop", 32'(S_READY), 1);
    end
    chk("drain_empty_mvalid", 32'(M_VALID), 0);
    chk("drain_empty_count", 32'(COUNT), 0);

    // streaming across six pointer wraps; occupancy is RAM word + output word
    nxt = 8'h80; pops0 = n_pop;
    S_VALID = 1'b1; M_READY = 1'b1;
    for (int i = 0; i < 200; i++) begin
      S_DATA = 8'(8'h80 + i);
      step();
      if (last_pop) begin
        chk("stream_order", 32'(last_out), 32'(nxt));
        nxt = nxt + 8'd1;
      end
      if (i >= 2) chk("stream_count", 32'(COUNT), 2);
    end
    S_VALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (last_pop) begin
        chk("stream_order", 32'(last_out), 32'(nxt));
        nxt = nxt + 8'd1;
      end
    end
    chk("stream_total", n_pop - pops0, 200);
    chk("stream_empty", 32'(COUNT), 0);

    // random stress against the queue model
    for (int p = 0; p < 4; p++) begin
      acc = 0; cyc = 0;
      while (acc < 2500 && cyc < 15000) begin
        S_VALID = ($urandom_range(0, 99) < pv[p]);
        S_DATA  = 8'($urandom);
        M_READY = ($urandom_range(0, 99) < pr[p]);
        step();
        if (last_push) acc++;
        cyc++;
        chk("rand_count", 32'(COUNT), q.size());
      end
      chk("rand_budget", acc, 2500);
    end
    S_VALID = 1'b0; M_READY = 1'b1;
    cyc = 0;
    while (q.size() != 0 && cyc < 100) begin
      step();
      cyc++;
    end
    chk("rand_drained", q.size(), 0);
    chk("rand_drained_count", 32'(COUNT), 0);

    // mid-operation reset with handshakes offered in the reset cycle
    M_READY = 1'b0; S_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      S_DATA = 8'(8'h10 + i);
      step();
    end
    chk("pre_reset_count", 32'(COUNT), 20);
    RST = 1'b1; M_READY = 1'b1;
    step();
    chk_reset_outs("midreset");
    RST = 1'b0; S_VALID = 1'b0; M_READY = 1'b0;
    step();
    chk("midreset_ready", 32'(S_READY), 1);
    chk("midreset_count", 32'(COUNT), 0);
    S_DATA = 8'h5A; S_VALID = 1'b1;
    step();
    S_VALID = 1'b0;
    step();
    chk("post_reset_mvalid", 32'(M_VALID), 1);
    chk("post_reset_first", 32'(M_DATA), 8'h5A);
    M_READY = 1'b1;
    step();
    chk("post_reset_empty", 32'(COUNT), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
